// File: rtl/coin_change_dispenser_if.sv
// Change-request and coin-strobe bundle between the machine controller (master)
// and the coin change dispenser (slave).
interface coin_change_dispenser_if #(
  parameter int AMT_W = 8
);
  // Handshake: a request transfers on a rising edge where req=1 and ready=1;
  // amount must be stable on that edge. req with ready=0 is dropped, never queued.
  logic             req;
  logic [AMT_W-1:0] amount;
  logic             quarter_avail;
  logic             dime_avail;
  logic             nickel_avail;
  logic             ready;
  logic             valid;
  logic             quarter;
  logic             dime;
  logic             nickel;
  logic             done;
  logic             error;
  logic [AMT_W-1:0] remaining;

  modport master (
    output req, amount, quarter_avail, dime_avail, nickel_avail,
    input  ready, valid, quarter, dime, nickel, done, error, remaining
  );

  modport slave (
    input  req, amount, quarter_avail, dime_avail, nickel_avail,
    output ready, valid, quarter, dime, nickel, done, error, remaining
  );
endinterface

// File: rtl/coin_change_dispenser.sv
// Pays out a change amount as largest-first coin strobes, skipping empty tubes,
// and finishes each transaction with a one-cycle done or error pulse.
module coin_change_dispenser #(
  parameter int AMT_W      = 8,
  parameter int MAX_CENTS  = 135,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  coin_change_dispenser_if.slave   bus,
  output logic [2:0]               state_dbg
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    COIN   = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [AMT_W-1:0] rem_n;
  logic [GW-1:0]    gap_cnt, gap_n;
  logic [2:0]       coin_n;
  logic             bad_amount;

  assign state_dbg  = state;
  assign bad_amount = (bus.amount > AMT_W'(MAX_CENTS)) ||
                      ((bus.amount % AMT_W'(5)) != '0);

  always_comb begin
    state_n = state;
    rem_n   = bus.remaining;
    gap_n   = gap_cnt;
    coin_n  = 3'b000;
    case (state)
      IDLE: begin
        if (bus.req) begin
          rem_n   = bus.amount;
          state_n = bad_amount ? ERR : SELECT;
        end
      end
      SELECT: begin
        // Greedy and final: a coin is taken only when it fits, so no underflow.
        if (bus.remaining == '0) begin
          state_n = DONE;
        end else if (bus.remaining >= AMT_W'(25) && bus.quarter_avail) begin
          state_n = COIN;
          coin_n  = 3'b100;
          rem_n   = bus.remaining - AMT_W'(25);
        end else if (bus.remaining >= AMT_W'(10) && bus.dime_avail) begin
          state_n = COIN;
          coin_n  = 3'b010;
          rem_n   = bus.remaining - AMT_W'(10);
        end else if (bus.remaining >= AMT_W'(5) && bus.nickel_avail) begin
          state_n = COIN;
          coin_n  = 3'b001;
          rem_n   = bus.remaining - AMT_W'(5);
        end else begin
          state_n = ERR;
        end
      end
      COIN: begin
        if (GAP_CYCLES == 0) begin
          state_n = SELECT;
        end else begin
          state_n = GAP;
          gap_n   = GW'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_n = SELECT;
        else               gap_n   = gap_cnt - GW'(1);
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are flopped from the next state so every strobe is a clean register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      gap_cnt       <= '0;
      bus.remaining <= '0;
      bus.ready     <= 1'b1;
      bus.valid     <= 1'b0;
      bus.quarter   <= 1'b0;
      bus.dime      <= 1'b0;
      bus.nickel    <= 1'b0;
      bus.done      <= 1'b0;
      bus.error     <= 1'b0;
    end else begin
      state         <= state_n;
      gap_cnt       <= gap_n;
      bus.remaining <= rem_n;
      bus.ready     <= (state_n == IDLE);
      bus.valid     <= (state_n == COIN);
      bus.quarter   <= coin_n[2];
      bus.dime      <= coin_n[1];
      bus.nickel    <= coin_n[0];
      bus.done      <= (state_n == DONE);
      bus.error     <= (state_n == ERR);
    end
  end

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Bench for coin_change_dispenser: table of change requests plus hand-written
// sequences for ignored mid-transaction requests and reset mid-payout.
module tb_coin_change_dispenser;

  localparam int AMT_W = 8;
  localparam int GAP   = 1;

  logic       clk;
  logic       reset_n;
  logic [2:0] state_dbg;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [2:0] exp_q[$];

  coin_change_dispenser_if #(.AMT_W(AMT_W)) bus ();

  coin_change_dispenser #(
    .AMT_W(AMT_W), .MAX_CENTS(135), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .state_dbg(state_dbg)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] amt;
    logic [2:0] av;   // {quarter, dime, nickel} tube non-empty
    int         n;
    bit         d;
    bit         e;
    logic [7:0] rem;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference greedy payout; pushes the expected coin sequence to exp_q.
  task automatic model(input logic [7:0] amt, input logic [2:0] av,
                       output int n, output bit d, output bit e, output logic [7:0] r);
    bit busy;
    n = 0; d = 0; e = 0; r = amt;
    if (amt > 8'd135 || (amt % 5) != 0) begin
      e = 1;
    end else begin
      busy = 1;
      while (busy) begin
        if (r == 0) begin
          d = 1; busy = 0;
        end else if (r >= 25 && av[2]) begin
          exp_q.push_back(3'b100); r = r - 8'd25; n++;
        end else if (r >= 10 && av[1]) begin
          exp_q.push_back(3'b010); r = r - 8'd10; n++;
        end else if (r >= 5 && av[0]) begin
          exp_q.push_back(3'b001); r = r - 8'd5; n++;
        end else begin
          e = 1; busy = 0;
        end
      end
    end
  endtask

  // Driver + monitor for one transaction. With noisy=1, req stays high with
  // junk amounts throughout the transaction, which must all be ignored.
  task automatic run_txn(input logic [7:0] amt, input logic [2:0] av, input bit noisy,
                         input int exp_n, input bit exp_d, input bit exp_e,
                         input logic [7:0] exp_rem);
    int  ncoins;
    int  lat;
    int  exp_lat;
    bit  bad;
    bad = (amt > 8'd135) || ((amt % 5) != 0);
    exp_lat = bad ? 0 : 1 + exp_n * (2 + GAP);
    for (int w = 0; w < 50 && bus.ready !== 1'b1; w++) @(negedge clk);
    check("ready_before_req", bus.ready, 1);
    {bus.quarter_avail, bus.dime_avail, bus.nickel_avail} = av;
    bus.req    = 1'b1;
    bus.amount = amt;
    @(posedge clk);
    #1;
    if (noisy) bus.amount = 8'($urandom_range(0, 255));
    else       bus.req    = 1'b0;
    ncoins = 0;
    lat    = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 0 && !bad) check("ready_low_busy", bus.ready, 0);
      if (bus.valid) begin
        check("coin_timing", i, 1 + ncoins * (2 + GAP));
        if (exp_q.size() == 0) check("coin_unexpected", {bus.quarter, bus.dime, bus.nickel}, 0);
        else check("coin_type", {bus.quarter, bus.dime, bus.nickel}, exp_q.pop_front());
        ncoins++;
      end else if ({bus.quarter, bus.dime, bus.nickel} != 3'b000) begin
        check("qual_without_valid", {bus.quarter, bus.dime, bus.nickel}, 0);
      end
      if (bus.done || bus.error) begin
        lat = i;
        break;
      end
    end
    bus.req = 1'b0;
    if (lat < 0) begin
      check("txn_timeout", 0, 1);
    end else begin
      check("end_latency", lat, exp_lat);
      check("done", bus.done, exp_d);
      check("error", bus.error, exp_e);
      check("remaining", bus.remaining, exp_rem);
    end
    check("coin_count", ncoins, exp_n);
    check("coins_missing", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check("ready_after", bus.ready, 1);
    check("pulse_width", {bus.done, bus.error}, 0);
  endtask

  initial begin
    int         n;
    bit         d, e;
    logic [7:0] r;
    logic [7:0] amt;
    logic [2:0] av;
    int         seen;

    vecs[0]  = '{8'd35,  3'b111, 2,  1, 0, 8'd0};
    vecs[1]  = '{8'd0,   3'b111, 0,  1, 0, 8'd0};
    vecs[2]  = '{8'd40,  3'b011, 4,  1, 0, 8'd0};
    vecs[3]  = '{8'd135, 3'b111, 6,  1, 0, 8'd0};
    vecs[4]  = '{8'd15,  3'b110, 1,  0, 1, 8'd5};
    vecs[5]  = '{8'd37,  3'b111, 0,  0, 1, 8'd37};
    vecs[6]  = '{8'd140, 3'b111, 0,  0, 1, 8'd140};
    vecs[7]  = '{8'd5,   3'b111, 1,  1, 0, 8'd0};
    vecs[8]  = '{8'd30,  3'b101, 2,  1, 0, 8'd0};
    vecs[9]  = '{8'd20,  3'b100, 0,  0, 1, 8'd20};
    vecs[10] = '{8'd10,  3'b101, 2,  1, 0, 8'd0};
    vecs[11] = '{8'd255, 3'b111, 0,  0, 1, 8'd255};
    vecs[12] = '{8'd130, 3'b001, 26, 1, 0, 8'd0};

    reset_n = 1'b0;
    bus.req = 1'b0;
    bus.amount = '0;
    {bus.quarter_avail, bus.dime_avail, bus.nickel_avail} = 3'b111;
    #12;
    check("reset_ready", bus.ready, 1);
    check("reset_strobes", {bus.valid, bus.quarter, bus.dime, bus.nickel, bus.done, bus.error}, 0);
    check("reset_remaining", bus.remaining, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 13; k++) begin
      model(vecs[k].amt, vecs[k].av, n, d, e, r);
      run_txn(vecs[k].amt, vecs[k].av, 1'b0, vecs[k].n, vecs[k].d, vecs[k].e, vecs[k].rem);
    end

    // Requests held high during a transaction must not start a second one.
    model(8'd35, 3'b111, n, d, e, r);
    run_txn(8'd35, 3'b111, 1'b1, 2, 1, 0, 8'd0);
    model(8'd37, 3'b111, n, d, e, r);
    run_txn(8'd37, 3'b111, 1'b1, 0, 0, 1, 8'd37);
    repeat (3) begin
      @(negedge clk);
      check("no_phantom_txn", bus.ready, 1);
    end

    for (int k = 0; k < 8; k++) begin
      amt = 8'($urandom_range(0, 27) * 5);
      av  = 3'($urandom_range(0, 7));
      model(amt, av, n, d, e, r);
      run_txn(amt, av, 1'b0, n, d, e, r);
    end

    // Reset one cycle after the first quarter of a 135-cent payout.
    {bus.quarter_avail, bus.dime_avail, bus.nickel_avail} = 3'b111;
    bus.req    = 1'b1;
    bus.amount = 8'd135;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.valid) seen = 1;
    end
    check("first_quarter_seen", seen, 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_ready", bus.ready, 1);
    check("rst_mid_strobes", {bus.valid, bus.quarter, bus.dime, bus.nickel, bus.done, bus.error}, 0);
    check("rst_mid_remaining", bus.remaining, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.valid || bus.done || bus.error) seen++;
    end
    check("no_pulses_after_reset", seen, 0);
    check("idle_after_reset", bus.ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
